zmod_txrst_seq: RTL and testbench

- Reset sequencer directly downstream of the TX PLL: watches the PLL `locked` output and drives the PLL reset.
- Releases the SERDES-side (x4) reset and the parallel-logic reset in order, only after lock has been stable.
- Runs on the free-running PLL reference clock, because PLL output clocks are invalid while unlocked.
- Reset outputs are asynchronously asserted levels; each consuming domain resynchronises deassertion locally.

---
 rtl/zmod_txrst_seq.sv | 151 +++++++++++++++
 tb/tb_zmod_txrst_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/zmod_txrst_seq.sv
// TX PLL reset sequencer: pulses the PLL reset, waits for stable lock, then releases serdes and logic resets in order.
// Status counters (lock_loss_cnt, timeout_cnt) exist only when ZMOD_TXRST_STATUS_EN is defined; otherwise they read 0.
module zmod_txrst_seq #(
    parameter int SYNC_STAGES      = 3,
    parameter int PLL_RST_CYCLES   = 16,
    parameter int LOCK_WAIT_CYCLES = 1024,
    parameter int LOCK_TIMEOUT     = 65536,
    parameter int RELEASE_GAP      = 16,
    parameter int CNT_W            = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             serdes_rst,
    output logic             logic_rst,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);
    localparam int PH_MAX = (PLL_RST_CYCLES > RELEASE_GAP) ? PLL_RST_CYCLES : RELEASE_GAP;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int STB_W  = $clog2(LOCK_WAIT_CYCLES + 1);
    localparam int TMO_W  = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_REL_SERDES,
        S_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [STB_W-1:0]       stable_q, stable_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   pll_rst_q, serdes_rst_q, logic_rst_q, ready_q;
    logic                   locked_s, lock_lost, lock_tmo;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            state_q      <= S_PLL_RST;
            phase_q      <= '0;
            stable_q     <= '0;
            tmo_q        <= '0;
            pll_rst_q    <= 1'b1;
            serdes_rst_q <= 1'b1;
            logic_rst_q  <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            state_q      <= state_d;
            phase_q      <= phase_d;
            stable_q     <= stable_d;
            tmo_q        <= tmo_d;
            pll_rst_q    <= (state_d == S_PLL_RST);
            serdes_rst_q <= (state_d == S_PLL_RST) || (state_d == S_WAIT_LOCK);
            logic_rst_q  <= (state_d != S_RUN);
            ready_q      <= (state_d == S_RUN);
        end
    end

    // Reset release acts as the entry edge of the first PLL pulse, so a
    // timeout re-entry preloads 1 to give every pulse the same length.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        stable_d  = stable_q;
        tmo_d     = tmo_q;
        lock_lost = 1'b0;
        lock_tmo  = 1'b0;
        unique case (state_q)
            S_PLL_RST: begin
                if (32'(phase_q) == PLL_RST_CYCLES) begin
                    state_d  = S_WAIT_LOCK;
                    phase_d  = '0;
                    stable_d = '0;
                    tmo_d    = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                stable_d = locked_s ? stable_q + 1'b1 : '0;
                tmo_d    = tmo_q + 1'b1;
                if (locked_s && (32'(stable_q) == LOCK_WAIT_CYCLES - 1)) begin
                    state_d = S_REL_SERDES;
                    phase_d = '0;
                end else if (32'(tmo_q) == LOCK_TIMEOUT - 1) begin
                    state_d  = S_PLL_RST;
                    phase_d  = PH_W'(1);
                    lock_tmo = 1'b1;
                end
            end
            S_REL_SERDES: begin
                if (!locked_s) begin
                    state_d   = S_WAIT_LOCK;
                    stable_d  = '0;
                    tmo_d     = '0;
                    lock_lost = 1'b1;
                end else if (32'(phase_q) == RELEASE_GAP - 1) begin
                    state_d = S_RUN;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d   = S_WAIT_LOCK;
                    stable_d  = '0;
                    tmo_d     = '0;
                    lock_lost = 1'b1;
                end
            end
        endcase
    end

    assign pll_rst    = pll_rst_q;
    assign serdes_rst = serdes_rst_q;
    assign logic_rst  = logic_rst_q;
    assign ready      = ready_q;

`ifdef ZMOD_TXRST_STATUS_EN
    logic [CNT_W-1:0] lock_loss_q, timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_loss_q <= '0;
            timeout_q   <= '0;
        end else begin
            if (lock_lost && (lock_loss_q != {CNT_W{1'b1}}))
                lock_loss_q <= lock_loss_q + 1'b1;
            if (lock_tmo && (timeout_q != {CNT_W{1'b1}}))
                timeout_q <= timeout_q + 1'b1;
        end
    end

    assign lock_loss_cnt = lock_loss_q;
    assign timeout_cnt   = timeout_q;
`else
    logic status_unused;
    assign status_unused = lock_lost ^ lock_tmo;
    assign lock_loss_cnt = '0;
    assign timeout_cnt   = '0;
`endif

endmodule

// File: tb/tb_zmod_txrst_seq.sv
// Bench for zmod_txrst_seq: boot table, hand-written corner sequences, and randomized lock patterns
// compared against a timestamp-based model of the sequencing rules.
module tb_zmod_txrst_seq;
    localparam int SYNC_STAGES = 2;
    localparam int PRC         = 4;
    localparam int LWC         = 8;
    localparam int LTO         = 32;
    localparam int RG          = 2;
    localparam int CNT_W       = 4;
    localparam int CMAX        = (1 << CNT_W) - 1;
`ifdef ZMOD_TXRST_STATUS_EN
    localparam bit STATUS_EN = 1'b1;
`else
    localparam bit STATUS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pll_locked = 1'b0;
    logic             pll_rst, serdes_rst, logic_rst, ready;
    logic [CNT_W-1:0] lock_loss_cnt, timeout_cnt;

    zmod_txrst_seq #(
        .SYNC_STAGES     (SYNC_STAGES),
        .PLL_RST_CYCLES  (PRC),
        .LOCK_WAIT_CYCLES(LWC),
        .LOCK_TIMEOUT    (LTO),
        .RELEASE_GAP     (RG),
        .CNT_W           (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .serdes_rst   (serdes_rst),
        .logic_rst    (logic_rst),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt),
        .timeout_cnt  (timeout_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {PH_PRST, PH_WAIT, PH_REL, PH_RUN} ph_t;
    typedef struct {
        int         edge_n;
        logic [3:0] outs;   // {pll_rst, serdes_rst, logic_rst, ready}
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;

    // Model: phase plus the edge it was entered at; lock/timeout/gap decided by edge arithmetic.
    ph_t  m_ph;
    int   m_e, m_t0, m_low, m_ll, m_tc;
    logic hist[$];

    function automatic int exp_cnt(input int v);
        return STATUS_EN ? v : 0;
    endfunction

    task automatic m_reset();
        m_ph  = PH_PRST;
        m_e   = 0;
        m_t0  = 0;
        m_low = -1;
        m_ll  = 0;
        m_tc  = 0;
        hist.delete();
    endtask

    task automatic model_edge(input logic v);
        logic ls;
        int   lo;
        hist.push_back(v);
        ls = (m_e >= SYNC_STAGES) ? hist[m_e - SYNC_STAGES] : 1'b0;
        if (!ls) m_low = m_e;
        lo = (m_low > m_t0) ? m_low : m_t0;
        case (m_ph)
            PH_PRST: if (m_e - m_t0 == PRC) begin m_ph = PH_WAIT; m_t0 = m_e; end
            PH_WAIT: begin
                if (m_e - lo == LWC) begin
                    m_ph = PH_REL; m_t0 = m_e;
                end else if (m_e - m_t0 == LTO) begin
                    m_ph = PH_PRST; m_t0 = m_e;
                    if (m_tc < CMAX) m_tc++;
                end
            end
            default: begin
                if (!ls) begin
                    m_ph = PH_WAIT; m_t0 = m_e;
                    if (m_ll < CMAX) m_ll++;
                end else if (m_ph == PH_REL && m_e - m_t0 == RG) begin
                    m_ph = PH_RUN;
                end
            end
        endcase
        m_e++;
    endtask

    task automatic check_const(input string tag, input logic [3:0] want, input int want_ll, input int want_tc);
        n_chk++;
        if ({pll_rst, serdes_rst, logic_rst, ready} !== want
            || int'(lock_loss_cnt) != want_ll || int'(timeout_cnt) != want_tc) begin
            n_fail++;
            $display("FAIL %s: got rst/rdy=%b cnts=%0d/%0d, want %b %0d/%0d", tag,
                     {pll_rst, serdes_rst, logic_rst, ready}, lock_loss_cnt, timeout_cnt,
                     want, want_ll, want_tc);
        end
    endtask

    task automatic check_model(input string tag);
        logic [3:0] want;
        want = {m_ph == PH_PRST, (m_ph == PH_PRST) || (m_ph == PH_WAIT), m_ph != PH_RUN, m_ph == PH_RUN};
        check_const($sformatf("%s_edge%0d", tag, m_e - 1), want, exp_cnt(m_ll), exp_cnt(m_tc));
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    task automatic tick(input logic v, input string tag);
        pll_locked = v;
        @(posedge clk);
        model_edge(v);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t boot_tbl[7];
        int   fall, rise, prev, lvl, run;

        boot_tbl = '{'{3, 4'b1110}, '{4, 4'b0110}, '{11, 4'b0110}, '{12, 4'b0010},
                     '{13, 4'b0010}, '{14, 4'b0001}, '{20, 4'b0001}};

        // Reset must take effect before any clock edge.
        #2 rst = 1'b1;
        #1 check_const("reset_async", 4'b1110, 0, 0);

        // Clean boot.
        do_reset();
        foreach (boot_tbl[i]) begin
            while (m_e <= boot_tbl[i].edge_n) tick(1'b1, "boot");
            check_const($sformatf("boot_tbl_e%0d", boot_tbl[i].edge_n), boot_tbl[i].outs, 0, 0);
        end

        // Lock glitch mid-WAIT_LOCK: edges 7..9 sample low.
        do_reset();
        while (m_e <= 6) tick(1'b1, "glitch");
        repeat (3) tick(1'b0, "glitch");
        fall = -1;
        for (int k = 0; k < 40 && fall < 0; k++) begin
            tick(1'b1, "glitch");
            if (!serdes_rst) fall = m_e - 1;
        end
        check_int("glitch_serdes_fall_edge", fall, 19);
        check_int("glitch_timeout_cnt", int'(timeout_cnt), 0);

        // Timeout: never locks.
        do_reset();
        rise = -1; fall = -1; prev = 1;
        for (int k = 0; k < 16 * 36 + 8; k++) begin
            tick(1'b0, "tmo");
            if (pll_rst && prev == 0 && rise < 0) rise = m_e - 1;
            else if (!pll_rst && prev == 1 && rise >= 0 && fall < 0) fall = m_e - 1;
            prev = int'(pll_rst);
        end
        check_int("tmo_repulse_rise_edge", rise, 36);
        check_int("tmo_repulse_fall_edge", fall, 40);
        check_int("tmo_cnt_saturated", int'(timeout_cnt), exp_cnt(15));

        // Lock loss in RUN: one low sample at edge 17.
        do_reset();
        while (m_e <= 16) tick(1'b1, "loss");
        tick(1'b0, "loss");
        fall = -1; rise = -1;
        for (int k = 0; k < 40; k++) begin
            tick(1'b1, "loss");
            if (fall < 0 && !ready) fall = m_e - 1;
            else if (fall >= 0 && rise < 0 && ready) rise = m_e - 1;
        end
        check_int("loss_ready_fall_edge", fall, 19);
        check_int("loss_ready_return_edge", rise, 29);
        check_int("loss_lock_loss_cnt", int'(lock_loss_cnt), exp_cnt(1));

        // Async reset while in REL_SERDES.
        do_reset();
        while (m_e <= 12) tick(1'b1, "arst");
        check_const("arst_in_rel", 4'b0010, 0, 0);
        #2 rst = 1'b1;
        #1 check_const("arst_immediate", 4'b1110, 0, 0);
        do_reset();
        fall = -1;
        for (int k = 0; k < 16; k++) begin
            tick(1'b1, "arst_reboot");
            if (fall < 0 && !pll_rst) fall = m_e - 1;
        end
        check_int("arst_reboot_pll_fall_edge", fall, 4);

        // Randomized lock patterns.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            lvl = 1; run = 0;
            for (int k = 0; k < 400; k++) begin
                if (run == 0) begin
                    lvl = 1 - lvl;
                    if (lvl == 1) run = int'($urandom_range(1, 40));
                    else run = ($urandom_range(0, 9) == 0) ? 45 : int'($urandom_range(1, 6));
                end
                run--;
                tick(lvl[0], "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
